// File: rtl/riscv_bus_pkg.sv
// Shared types and constants for the RISC-V system bus interconnect.
package riscv_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned DEV_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } bus_state_t;

  localparam logic [DEV_W-1:0] DEV_DMEM    = 8'h00;
  localparam logic [DEV_W-1:0] DEV_UART_RX = 8'h05;
  localparam logic [DEV_W-1:0] DEV_UART_TX = 8'h06;

  localparam logic [DATA_W-1:0] BUS_ERR_RDATA = 32'h0;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
  } bus_req_t;

  // Slaves see only the in-device offset; the device field is stripped.
  function automatic logic [ADDR_W-1:0] slave_addr(input logic [ADDR_W-1:0] a);
    return {DEV_W'(0), a[ADDR_W-DEV_W-1:0]};
  endfunction

endpackage

// File: rtl/riscv_sys_bus_if.sv
// Host-side port of the system bus: request fields in, completion out.
interface riscv_sys_bus_if;
  import riscv_bus_pkg::*;

  logic              req_i;
  logic              we_i;
  logic [BE_W-1:0]   be_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wd_i;
  logic [DATA_W-1:0] rd_o;
  logic              ready_o;
  logic              err_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wd_i,
    input  rd_o, ready_o, err_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wd_i,
    output rd_o, ready_o, err_o
  );

endinterface

// File: rtl/riscv_bus_decoder.sv
// Device-field decoder: maps addr[31:24] to a slot, lowest matching slot wins.
module riscv_bus_decoder
  import riscv_bus_pkg::*;
#(
  parameter int unsigned              NUM_SLOTS = 8,
  parameter logic [NUM_SLOTS*8-1:0]   SLOT_MAP  = {8'h07, 8'h06, 8'h05, 8'h04,
                                                   8'h03, 8'h02, 8'h01, 8'h00},
  localparam int unsigned             IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic [DEV_W-1:0]     dev_i,
  output logic [NUM_SLOTS-1:0] sel_oh_c_o,
  output logic [IDX_W-1:0]     sel_idx_c_o,
  output logic                 hit_c_o
);

  // Scan downward so a lower-index match overrides any higher one.
  always_comb begin
    sel_oh_c_o  = '0;
    sel_idx_c_o = '0;
    hit_c_o     = 1'b0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (SLOT_MAP[k*8 +: 8] == dev_i) begin
        sel_oh_c_o    = '0;
        sel_oh_c_o[k] = 1'b1;
        sel_idx_c_o   = IDX_W'(k);
        hit_c_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_sys_bus.sv
// Single-outstanding system bus: decodes the device field, forwards one
// transaction to the selected slave and returns a registered response.
module riscv_sys_bus
  import riscv_bus_pkg::*;
#(
  parameter int unsigned            NUM_SLOTS = 8,
  parameter logic [NUM_SLOTS*8-1:0] SLOT_MAP  = {8'h07, 8'h06, 8'h05, 8'h04,
                                                 8'h03, 8'h02, 8'h01, 8'h00},
  parameter int unsigned            TIMEOUT   = 255
) (
  input  logic                        clk_i,
  input  logic                        resetn_i,
  riscv_sys_bus_if.slave              hst,
  output logic [ADDR_W-1:0]           fault_addr_o,
  output logic [NUM_SLOTS-1:0]        slv_req_o,
  output logic                        slv_we_o,
  output logic [BE_W-1:0]             slv_be_o,
  output logic [ADDR_W-1:0]           slv_addr_o,
  output logic [DATA_W-1:0]           slv_wd_o,
  input  logic [NUM_SLOTS*DATA_W-1:0] slv_rd_i,
  input  logic [NUM_SLOTS-1:0]        slv_ready_i
);

  localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  bus_state_t            state_q;
  bus_req_t              req_q;
  logic [IDX_W-1:0]      sel_q;
  logic [NUM_SLOTS-1:0]  slv_req_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]     rd_q;
  logic                  err_q;
  logic                  ready_q;
  logic [ADDR_W-1:0]     fault_q;

  logic [NUM_SLOTS-1:0]  dec_oh_c;
  logic [IDX_W-1:0]      dec_idx_c;
  logic                  dec_hit_c;
  logic                  sel_ready_c;
  logic [DATA_W-1:0]     sel_rd_c;
  logic [CNT_W-1:0]      cnt_inc_c;
  logic                  timeout_c;

  riscv_bus_decoder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_MAP  (SLOT_MAP)
  ) u_dec (
    .dev_i       (hst.addr_i[ADDR_W-1 -: DEV_W]),
    .sel_oh_c_o  (dec_oh_c),
    .sel_idx_c_o (dec_idx_c),
    .hit_c_o     (dec_hit_c)
  );

  // Only the latched slot is ever listened to.
  assign sel_ready_c = slv_ready_i[sel_q];
  assign sel_rd_c    = slv_rd_i[32'(sel_q) * DATA_W +: DATA_W];
  assign cnt_inc_c   = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_c   = (cnt_inc_c == CNT_W'(TIMEOUT));

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= IDLE;
      req_q     <= '0;
      sel_q     <= '0;
      slv_req_q <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= '0;
    end else begin
      // Response registers are live only during RESP; the idle bus reads zero.
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= '0;
      slv_req_q <= '0;
      case (state_q)
        IDLE: begin
          if (hst.req_i) begin
            req_q <= bus_req_t'{hst.we_i, hst.be_i, hst.addr_i, hst.wd_i};
            sel_q <= dec_idx_c;
            if (dec_hit_c) begin
              slv_req_q <= dec_oh_c;
              state_q   <= ISSUE;
            end else begin
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              rd_q    <= BUS_ERR_RDATA;
              state_q <= RESP;
            end
          end
        end
        ISSUE: begin
          cnt_q <= '0;
          if (sel_ready_c) begin
            ready_q <= 1'b1;
            rd_q    <= req_q.we ? '0 : sel_rd_c;
            state_q <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_inc_c;
          if (sel_ready_c) begin
            ready_q <= 1'b1;
            rd_q    <= req_q.we ? '0 : sel_rd_c;
            state_q <= RESP;
          end else if (timeout_c) begin
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            rd_q    <= BUS_ERR_RDATA;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (err_q) begin
            fault_q <= req_q.addr;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hst.rd_o     = rd_q;
  assign hst.ready_o  = ready_q;
  assign hst.err_o    = err_q;
  assign fault_addr_o = fault_q;
  assign slv_req_o    = slv_req_q;
  assign slv_we_o     = req_q.we;
  assign slv_be_o     = req_q.be;
  assign slv_addr_o   = slave_addr(req_q.addr);
  assign slv_wd_o     = req_q.wd;

endmodule

// File: tb/tb_riscv_sys_bus.sv
// Scoreboard bench for riscv_sys_bus: directed requests push expectations,
// a negedge monitor pops and checks each completion.
module tb_riscv_sys_bus;

  localparam int unsigned NS = 8;
  localparam int unsigned TO = 8;
  localparam logic [NS*8-1:0] MAP = {8'h07, 8'h06, 8'h05, 8'h04,
                                     8'h02, 8'h01, 8'h02, 8'h00};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  riscv_sys_bus_if hst();

  logic [31:0]      fault_addr;
  logic [NS-1:0]    slv_req;
  logic             slv_we;
  logic [3:0]       slv_be;
  logic [31:0]      slv_addr;
  logic [31:0]      slv_wd;
  logic [NS*32-1:0] slv_rd;
  logic [NS-1:0]    slv_ready;
  logic [NS-1:0]    noise;

  riscv_sys_bus #(.NUM_SLOTS(NS), .SLOT_MAP(MAP), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .hst          (hst),
    .fault_addr_o (fault_addr),
    .slv_req_o    (slv_req),
    .slv_we_o     (slv_we),
    .slv_be_o     (slv_be),
    .slv_addr_o   (slv_addr),
    .slv_wd_o     (slv_wd),
    .slv_rd_i     (slv_rd),
    .slv_ready_i  (slv_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_ready_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: wait_n[k]=0 answers in the request cycle, n answers in the nth wait cycle.
  int          wait_n [NS];
  logic [31:0] rdata  [NS];
  logic        busy   [NS];
  int          scnt   [NS];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NS; k++) begin
        busy[k] <= 1'b0;
        scnt[k] <= 0;
      end
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (slv_req[k] && wait_n[k] > 0) begin
          busy[k] <= 1'b1;
          scnt[k] <= 1;
        end else if (busy[k]) begin
          if (scnt[k] == wait_n[k]) busy[k] <= 1'b0;
          else scnt[k] <= scnt[k] + 1;
        end
      end
    end
  end

  always_comb begin
    slv_ready = noise;
    for (int k = 0; k < NS; k++) begin
      if ((slv_req[k] && wait_n[k] == 0) || (busy[k] && scnt[k] == wait_n[k]))
        slv_ready[k] = 1'b1;
    end
  end

  always_comb begin
    slv_rd = '0;
    for (int k = 0; k < NS; k++) slv_rd[k*32 +: 32] = rdata[k];
  end

  typedef struct {
    int          tag;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          cyc_req;
    logic [7:0]  oh;
    logic        we;
    logic [3:0]  be;
    logic [31:0] saddr;
    logic [31:0] wd;
  } exp_t;

  exp_t expq[$];

  task automatic chk(input string name, input int tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s tag=%0d actual=%h expected=%h", name, tag, act, exp);
    end
  endtask

  // Monitor: accumulate slave-side activity, check it all when ready_o shows up.
  logic [NS-1:0] acc;
  int            ncyc;
  logic [31:0]   c_addr, c_wd;
  logic [3:0]    c_be;
  logic          c_we;
  exp_t          me;

  always @(negedge clk) begin
    if (!resetn) begin
      acc  = '0;
      ncyc = 0;
    end else begin
      if (slv_req != '0) begin
        acc    = acc | slv_req;
        ncyc   = ncyc + 1;
        c_addr = slv_addr;
        c_be   = slv_be;
        c_we   = slv_we;
        c_wd   = slv_wd;
      end
      if (hst.ready_o) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready actual=1 expected=0");
        end else begin
          me = expq.pop_front();
          chk("rd", me.tag, hst.rd_o, me.rd);
          chk("err", me.tag, 32'(hst.err_o), 32'(me.err));
          chk("latency", me.tag, 32'(cyc - me.cyc_req + 1), 32'(me.lat));
          chk("slv_req", me.tag, 32'(acc), 32'(me.oh));
          chk("req_cycles", me.tag, 32'(ncyc), (me.oh != '0) ? 32'd1 : 32'd0);
          if (me.oh != '0) begin
            chk("slv_addr", me.tag, c_addr, me.saddr);
            chk("slv_be", me.tag, 32'(c_be), 32'(me.be));
            chk("slv_we", me.tag, 32'(c_we), 32'(me.we));
            chk("slv_wd", me.tag, c_wd, me.wd);
          end
        end
        acc            = '0;
        ncyc           = 0;
        last_ready_cyc = cyc;
        done_cnt++;
      end
    end
  end

  task automatic do_req(input int tag, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input logic [7:0] exp_oh);
    exp_t e;
    int   start;
    @(posedge clk); #1;
    hst.req_i  = 1'b1;
    hst.we_i   = we;
    hst.be_i   = be;
    hst.addr_i = addr;
    hst.wd_i   = wd;
    e.tag = tag;  e.rd = exp_rd;  e.err = exp_err;  e.lat = exp_lat;
    e.cyc_req = cyc;  e.oh = exp_oh;  e.we = we;  e.be = be;
    e.saddr = {8'h00, addr[23:0]};  e.wd = wd;
    expq.push_back(e);
    start = done_cnt;
    @(posedge clk); #1;
    hst.req_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done_cnt != start) break;
    end
    if (done_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL response_timeout tag=%0d actual=no_ready expected=ready", tag);
      if (expq.size() > 0) void'(expq.pop_back());
    end
  endtask

  task automatic check_fault(input int tag, input logic [31:0] exp);
    @(negedge clk);
    chk("fault_addr", tag, fault_addr, exp);
  endtask

  task automatic zero_checks(input int tag);
    chk("rst_ready", tag, 32'(hst.ready_o), 32'd0);
    chk("rst_err", tag, 32'(hst.err_o), 32'd0);
    chk("rst_rd", tag, hst.rd_o, 32'd0);
    chk("rst_fault", tag, fault_addr, 32'd0);
    chk("rst_slv_req", tag, 32'(slv_req), 32'd0);
    chk("rst_slv_we", tag, 32'(slv_we), 32'd0);
    chk("rst_slv_be", tag, 32'(slv_be), 32'd0);
    chk("rst_slv_addr", tag, slv_addr, 32'd0);
    chk("rst_slv_wd", tag, slv_wd, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r1;
    hst.req_i = 1'b0;  hst.we_i = 1'b0;  hst.be_i = '0;
    hst.addr_i = '0;   hst.wd_i = '0;
    noise = '0;
    for (int k = 0; k < NS; k++) wait_n[k] = 0;
    rdata[0] = 32'hCAFE_0001;  rdata[1] = 32'h1111_0001;
    rdata[2] = 32'h2222_0002;  rdata[3] = 32'h3333_0003;
    rdata[4] = 32'h4444_0004;  rdata[5] = 32'hBEEF_0005;
    rdata[6] = 32'hDEAD_0006;  rdata[7] = 32'h7777_0007;

    #2;
    zero_checks(0);
    #10 resetn = 1'b1;

    // Zero-wait read from slot 0.
    do_req(1, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'hCAFE_0001, 1'b0, 3, 8'h01);
    // Write with four wait states to slot 6; writes return zero.
    wait_n[6] = 4;
    do_req(2, 1'b1, 4'b0011, 32'h0600_0004, 32'h1234_5678, 32'h0, 1'b0, 7, 8'h40);
    // Zero-wait write to slot 2.
    do_req(3, 1'b1, 4'hF, 32'h0100_0000, 32'hAAAA_5555, 32'h0, 1'b0, 3, 8'h04);
    // Unmapped device.
    do_req(4, 1'b0, 4'hF, 32'h4200_0000, 32'h0, 32'h0, 1'b1, 2, 8'h00);
    check_fault(4, 32'h4200_0000);
    // Timeout on slot 5 while slot 4 holds ready high.
    wait_n[5] = 1000;
    noise = 8'h10;
    do_req(5, 1'b0, 4'hF, 32'h0500_0020, 32'h0, 32'h0, 1'b1, 11, 8'h20);
    noise = '0;
    check_fault(5, 32'h0500_0020);
    // Ready in the very cycle the counter reaches TIMEOUT wins.
    wait_n[5] = 8;
    do_req(6, 1'b0, 4'hF, 32'h0500_0024, 32'h0, 32'hBEEF_0005, 1'b0, 11, 8'h20);
    check_fault(6, 32'h0500_0020);

    // Reset asserted while the bus is waiting on slot 6.
    wait_n[6] = 1000;
    @(posedge clk); #1;
    hst.req_i = 1'b1;  hst.we_i = 1'b1;  hst.be_i = 4'hF;
    hst.addr_i = 32'h0600_0008;  hst.wd_i = 32'hA5A5_5A5A;
    @(posedge clk); #1;
    hst.req_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1 zero_checks(7);
    @(posedge clk); #3 resetn = 1'b1;

    do_req(8, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'hCAFE_0001, 1'b0, 3, 8'h01);
    check_fault(8, 32'h0);

    // Back-to-back reads to a device mapped on slots 1 and 3.
    wait_n[1] = 0;
    wait_n[3] = 0;
    do_req(9, 1'b0, 4'hF, 32'h0200_0000, 32'h0, 32'h1111_0001, 1'b0, 3, 8'h02);
    r1 = last_ready_cyc;
    do_req(10, 1'b0, 4'hF, 32'h0200_0000, 32'h0, 32'h1111_0001, 1'b0, 3, 8'h02);
    chk("b2b_gap", 10, 32'(last_ready_cyc - r1), 32'd3);

    repeat (3) @(posedge clk);
    chk("queue_empty", 11, 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
